// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the 16-bit MIPS-style datapath.
// Fetches over imemReq/imemReady, decodes into held control fields and
// sequences EXEC/MEM/WB, raising one pcEn per retired instruction.
// Optional build macro CTRL_RETIRE_CNT_EN adds the retired-instruction
// counter on retireCnt; without it retireCnt is tied to zero.
//
// state  | meaning
// FETCH  | request instruction, latch IR when imemReady
// DECODE | decode IR into control fields held for the instruction
// EXEC   | resolve branch/jump/illegal, dispatch to MEM or WB
// MEM    | data access held until dmemReady
// WB     | one-cycle register write with PC update
// FAULT  | memory timeout or illegal op, held until reset
module multicycle_ctrl #(
    parameter int MAX_WAIT       = 255,
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] imemData,
    input  logic        imemReady,
    input  logic        dmemReady,
    input  logic        zero,
    output logic        imemReq,
    output logic        dmemReq,
    output logic        memWrite,
    output logic [15:0] instruction,
    output logic        regWrite,
    output logic [1:0]  regDst,
    output logic [1:0]  memToReg,
    output logic [1:0]  jump,
    output logic [1:0]  aluSrc,
    output logic        pcSrc,
    output logic [2:0]  aluCtrl,
    output logic        pcEn,
    output logic        fault,
    output logic [15:0] retireCnt
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, FAULT} state_t;
    typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JUMP, K_LINK, K_ILLEGAL} kind_t;

    // last unready cycle before the timeout trips
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state, state_nxt;
    kind_t      kind, dec_kind;
    logic       armed;
    logic       waiting;
    logic [7:0] wait_cnt;
    logic [1:0] dec_reg_dst, dec_mem_to_reg, dec_jump, dec_alu_src;
    logic [2:0] dec_alu_ctrl;

    // decode the latched IR into instruction kind and datapath controls
    always_comb begin
        dec_kind       = K_ILLEGAL;
        dec_reg_dst    = 2'b00;
        dec_mem_to_reg = 2'b00;
        dec_jump       = 2'b00;
        dec_alu_src    = 2'b00;
        dec_alu_ctrl   = 3'b000;
        case (instruction[15:12])
            4'h0: begin
                dec_kind    = K_ALU;
                dec_reg_dst = 2'b01;
                case (instruction[2:0])
                    3'b000:  dec_alu_ctrl = 3'b000;
                    3'b001:  dec_alu_ctrl = 3'b001;
                    3'b010:  dec_alu_ctrl = 3'b010;
                    3'b011:  dec_alu_ctrl = 3'b110;
                    3'b100:  dec_alu_ctrl = 3'b111;
                    default: begin
                        dec_kind    = K_ILLEGAL;
                        dec_reg_dst = 2'b00;
                    end
                endcase
            end
            4'h1: begin
                dec_kind     = K_ALU;
                dec_alu_src  = 2'b01;
                dec_alu_ctrl = 3'b010;
            end
            4'h2: begin
                dec_kind     = K_ALU;
                dec_alu_src  = 2'b10;
                dec_alu_ctrl = 3'b001;
            end
            4'h3: begin
                dec_kind       = K_LOAD;
                dec_alu_src    = 2'b01;
                dec_alu_ctrl   = 3'b010;
                dec_mem_to_reg = 2'b01;
            end
            4'h4: begin
                dec_kind     = K_STORE;
                dec_alu_src  = 2'b01;
                dec_alu_ctrl = 3'b010;
            end
            4'h5: begin
                dec_kind     = K_BRANCH;
                dec_alu_ctrl = 3'b110;
            end
            4'h6: begin
                dec_kind = K_JUMP;
                dec_jump = 2'b01;
            end
            4'h7: begin
                dec_kind       = K_LINK;
                dec_jump       = 2'b01;
                dec_reg_dst    = 2'b10;
                dec_mem_to_reg = 2'b10;
            end
            4'h8: begin
                dec_kind = K_JUMP;
                dec_jump = 2'b10;
            end
            default: dec_kind = K_ILLEGAL;
        endcase
    end

    assign waiting = (state == FETCH && armed && !imemReady) || (state == MEM && !dmemReady);

    // state, wait counter, IR and held control fields; armed delays the first request past reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            armed       <= 1'b0;
            wait_cnt    <= 8'd0;
            instruction <= 16'h0000;
            kind        <= K_ILLEGAL;
            regDst      <= 2'b00;
            memToReg    <= 2'b00;
            jump        <= 2'b00;
            aluSrc      <= 2'b00;
            aluCtrl     <= 3'b000;
        end else begin
            state    <= state_nxt;
            armed    <= 1'b1;
            wait_cnt <= waiting ? wait_cnt + 8'd1 : 8'd0;
            if (state == FETCH && armed && imemReady)
                instruction <= imemData;
            if (state == DECODE) begin
                kind     <= dec_kind;
                regDst   <= dec_reg_dst;
                memToReg <= dec_mem_to_reg;
                jump     <= dec_jump;
                aluSrc   <= dec_alu_src;
                aluCtrl  <= dec_alu_ctrl;
            end
        end
    end

    // next-state and strobe outputs
    always_comb begin
        state_nxt = state;
        imemReq   = 1'b0;
        dmemReq   = 1'b0;
        memWrite  = 1'b0;
        regWrite  = 1'b0;
        pcEn      = 1'b0;
        pcSrc     = 1'b0;
        case (state)
            FETCH: begin
                if (armed) begin
                    imemReq = 1'b1;
                    if (imemReady)
                        state_nxt = DECODE;
                    else if (wait_cnt == WAIT_LAST)
                        state_nxt = FAULT;
                end
            end
            DECODE: state_nxt = EXEC;
            EXEC: begin
                case (kind)
                    K_BRANCH: begin
                        pcSrc     = zero;
                        pcEn      = 1'b1;
                        state_nxt = FETCH;
                    end
                    K_JUMP: begin
                        pcEn      = 1'b1;
                        state_nxt = FETCH;
                    end
                    K_LINK: begin
                        pcEn      = 1'b1;
                        regWrite  = 1'b1;
                        state_nxt = FETCH;
                    end
                    K_LOAD, K_STORE: state_nxt = MEM;
                    K_ALU:           state_nxt = WB;
                    default: begin
                        if (NOP_ON_ILLEGAL) begin
                            pcEn      = 1'b1;
                            state_nxt = FETCH;
                        end else begin
                            state_nxt = FAULT;
                        end
                    end
                endcase
            end
            MEM: begin
                dmemReq  = 1'b1;
                memWrite = (kind == K_STORE);
                if (dmemReady) begin
                    if (kind == K_STORE) begin
                        pcEn      = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = FAULT;
                end
            end
            WB: begin
                regWrite  = 1'b1;
                pcEn      = 1'b1;
                state_nxt = FETCH;
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = FETCH;
        endcase
    end

    assign fault = (state == FAULT);

`ifdef CTRL_RETIRE_CNT_EN
    // count retired instructions, one per pcEn pulse, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (!rst)
            retireCnt <= 16'h0000;
        else if (pcEn)
            retireCnt <= retireCnt + 16'd1;
    end
`else
    assign retireCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl with a transaction-level model:
// each instruction's expected latency, strobe counts and control fields
// are derived from its opcode class and the memory delays applied.
module tb_multicycle_ctrl;

    localparam int MAX_WAIT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] imemData = 16'h0000;
    logic        imemReady = 1'b0;
    logic        dmemReady = 1'b0;
    logic        zero = 1'b0;
    logic        imemReq, dmemReq, memWrite, regWrite, pcSrc, pcEn, fault;
    logic [15:0] instruction, retireCnt;
    logic [1:0]  regDst, memToReg, jump, aluSrc;
    logic [2:0]  aluCtrl;

    int checks = 0;
    int failures = 0;
    int exp_ret = 0;

    multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .NOP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .imemData(imemData), .imemReady(imemReady),
        .dmemReady(dmemReady), .zero(zero), .imemReq(imemReq), .dmemReq(dmemReq),
        .memWrite(memWrite), .instruction(instruction), .regWrite(regWrite),
        .regDst(regDst), .memToReg(memToReg), .jump(jump), .aluSrc(aluSrc),
        .pcSrc(pcSrc), .aluCtrl(aluCtrl), .pcEn(pcEn), .fault(fault),
        .retireCnt(retireCnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // 0 alu, 1 load, 2 store, 3 beq, 4 j/jr, 5 jal, 6 illegal
    function automatic int kind_of(input logic [15:0] ins);
        case (ins[15:12])
            4'h0:       return (ins[2:0] <= 3'd4) ? 0 : 6;
            4'h1, 4'h2: return 0;
            4'h3:       return 1;
            4'h4:       return 2;
            4'h5:       return 3;
            4'h6, 4'h8: return 4;
            4'h7:       return 5;
            default:    return 6;
        endcase
    endfunction

    // expected {regDst, memToReg, jump, aluSrc, aluCtrl}
    function automatic logic [10:0] exp_ctrl(input logic [15:0] ins);
        logic [1:0] rd, mr, jp, as;
        logic [2:0] ac;
        logic [2:0] rtab [0:7];
        rtab = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7, 3'd0, 3'd0, 3'd0};
        rd = 2'd0; mr = 2'd0; jp = 2'd0; as = 2'd0; ac = 3'd0;
        case (ins[15:12])
            4'h0: begin rd = 2'd1; ac = rtab[ins[2:0]]; end
            4'h1: begin as = 2'd1; ac = 3'd2; end
            4'h2: begin as = 2'd2; ac = 3'd1; end
            4'h3: begin as = 2'd1; ac = 3'd2; mr = 2'd1; end
            4'h4: begin as = 2'd1; ac = 3'd2; end
            4'h5: ac = 3'd6;
            4'h6: jp = 2'd1;
            4'h7: begin jp = 2'd1; rd = 2'd2; mr = 2'd2; end
            4'h8: jp = 2'd2;
            default: ;
        endcase
        return {rd, mr, jp, as, ac};
    endfunction

    function automatic logic [15:0] exp_retire();
`ifdef CTRL_RETIRE_CNT_EN
        return 16'(exp_ret);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic reset_dut();
        rst = 1'b0;
        imemReady = 1'b0;
        dmemReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_strobes", 32'({imemReq, dmemReq, memWrite, regWrite, pcEn, pcSrc, fault}), 32'd0);
        check_val("rst_ir", 32'(instruction), 32'd0);
        check_val("rst_ctrl", 32'({regDst, memToReg, jump, aluSrc, aluCtrl}), 32'd0);
        check_val("rst_retire", 32'(retireCnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_ret = 0;
    endtask

    // runs one instruction; entered and left at posedge+1
    task automatic run_instr(input logic [15:0] ins, input int idly, input int ddly, input logic z);
        int k, fetch_n, mem_n, acc, rw, dreq, mw, early, kd, exp_lat;
        bit done, accepted;
        logic rw_pc, ps_pc;
        logic [10:0] ctrl_pc;
        logic [15:0] ir_pc, ret_pc;
        kd = kind_of(ins);
        imemData = ins;
        zero = z;
        k = 0; fetch_n = 0; mem_n = 0; acc = 0; rw = 0; dreq = 0; mw = 0; early = 0;
        done = 1'b0; accepted = 1'b0;
        rw_pc = 1'b0; ps_pc = 1'b0; ctrl_pc = '0; ir_pc = '0; ret_pc = '0;
        while (!done && k < 600) begin
            imemReady = !accepted && (fetch_n >= idly);
            dmemReady = (mem_n >= ddly);
            @(negedge clk);
            if (!accepted) begin
                if (pcEn || regWrite || dmemReq) early++;
                if (imemReq) begin
                    if (imemReady) begin
                        accepted = 1'b1;
                        acc = 1;
                    end else begin
                        fetch_n++;
                    end
                end
            end else begin
                acc++;
            end
            if (accepted) begin
                rw   += int'(regWrite);
                dreq += int'(dmemReq);
                mw   += int'(memWrite);
                if (dmemReq) mem_n++;
                if (pcEn) begin
                    done    = 1'b1;
                    rw_pc   = regWrite;
                    ps_pc   = pcSrc;
                    ctrl_pc = {regDst, memToReg, jump, aluSrc, aluCtrl};
                    ir_pc   = instruction;
                    ret_pc  = retireCnt;
                end
            end
            if (fault) k = 600;
            @(posedge clk);
            #1;
            k++;
        end
        imemReady = 1'b0;
        dmemReady = 1'b0;
        check_val("retired", 32'(done), 32'd1);
        if (done) begin
            case (kd)
                0:       exp_lat = 4;
                1:       exp_lat = 5 + ddly;
                2:       exp_lat = 4 + ddly;
                default: exp_lat = 3;
            endcase
            check_val("latency", 32'(acc), 32'(exp_lat));
            check_val("regwr_cnt", 32'(rw), (kd == 0 || kd == 1 || kd == 5) ? 32'd1 : 32'd0);
            check_val("regwr_at_pcen", 32'(rw_pc), (kd == 0 || kd == 1 || kd == 5) ? 32'd1 : 32'd0);
            check_val("dmem_cycles", 32'(dreq), (kd == 1 || kd == 2) ? 32'(ddly + 1) : 32'd0);
            check_val("memwrite_cycles", 32'(mw), (kd == 2) ? 32'(ddly + 1) : 32'd0);
            check_val("pcsrc", 32'(ps_pc), (kd == 3) ? 32'(z) : 32'd0);
            check_val("instr", 32'(ir_pc), 32'(ins));
            if (kd != 6) check_val("ctrl", 32'(ctrl_pc), 32'(exp_ctrl(ins)));
            check_val("retire_cnt", 32'(ret_pc), 32'(exp_retire()));
            check_val("early_strobe", 32'(early), 32'd0);
            exp_ret++;
        end
    endtask

    task automatic fault_test();
        int n, k, bad;
        n = 0; k = 0; bad = 0;
        imemReady = 1'b0;
        while (k < 400) begin
            @(negedge clk);
            if (fault) k = 400;
            else if (imemReq) n++;
            if (pcEn) bad++;
            @(posedge clk);
            #1;
            k++;
        end
        check_val("timeout_req_cycles", 32'(n), 32'(MAX_WAIT));
        imemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (imemReq || pcEn || regWrite || dmemReq || !fault) bad++;
            @(posedge clk);
            #1;
        end
        check_val("fault_hold", 32'(bad), 32'd0);
        imemReady = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_ret = 0;
        @(negedge clk);
        check_val("fault_cleared", 32'(fault), 32'd0);
        check_val("req_after_rst", 32'(imemReq), 32'd0);
        @(negedge clk);
        check_val("req_next_cycle", 32'(imemReq), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic sw_reset_test();
        int seen, k;
        logic [15:0] ret_before;
        seen = 0; k = 0; ret_before = '0;
        imemData = 16'h4285;
        imemReady = 1'b1;
        dmemReady = 1'b0;
        while (seen < 2 && k < 20) begin
            @(negedge clk);
            if (dmemReq) seen++;
            ret_before = retireCnt;
            @(posedge clk);
            #1;
            k++;
        end
        check_val("sw_in_mem", 32'(seen), 32'd2);
        check_val("sw_retire_before", 32'(ret_before), 32'(exp_retire()));
        rst = 1'b0;
        @(negedge clk);
        check_val("sw_mem_pre_rst", 32'({dmemReq, memWrite, pcEn}), 32'b110);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("sw_rst_drop", 32'({dmemReq, memWrite, pcEn}), 32'd0);
        check_val("sw_rst_retire", 32'(retireCnt), 32'd0);
        imemReady = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_ret = 0;
    endtask

    initial begin
        logic [15:0] ins;
        reset_dut();
        run_instr(16'h0E8A, 0, 0, 1'b0);
        run_instr(16'h3285, 0, 3, 1'b0);
        run_instr(16'h5043, 0, 0, 1'b1);
        run_instr(16'h5043, 1, 0, 1'b0);
        run_instr(16'h7123, 0, 0, 1'b0);
        run_instr(16'h4285, 2, 1, 1'b0);
        run_instr(16'h0E8F, 0, 0, 1'b0);
        run_instr(16'hB000, 1, 0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            ins = 16'($urandom);
            run_instr(ins, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)));
        end
        fault_test();
        run_instr(16'h1123, 0, 0, 1'b0);
        sw_reset_test();
        run_instr(16'h8200, 0, 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
